lf_spi_cmd_rx: RTL and testbench
================================

// Module: lf_spi_cmd_rx
// PURPOSE
//  ARM->FPGA command receiver for the LF image, the stage directly upstream of the LF mode muxes.
//  Oversamples spck/mosi/ncs in the pck0 domain and assembles 16-bit frames {C[3:0],D[11:0]}.
//  Decodes SET_CONFREG(1), SET_DIVISOR(2) and SET_EDGE_DETECT_THRESHOLD(3) into registered
//  conf_word/divisor/lf_ed_threshold with one-cycle update strobes; rejects malformed frames.
// PARAMETERS
//  FRAME_BITS        16   bits per frame; a frame is accepted only with exactly this count
//  SYNC_STAGES       2    flip-flop synchronizer depth on spck, mosi, ncs (min 2)
//  DEFAULT_DIVISOR   95   divisor reset value (125 kHz at 24 MHz pck0)
//  DEFAULT_THRESHOLD 127  lf_ed_threshold reset value; also loaded on CONFREG to mode 001
// PORTS
//  pck0            in   1   sole clock; all logic on rising edge
//  nreset          in   1   synchronous active-low reset
//  spck            in   1   SPI clock from ARM, asynchronous to pck0
//  mosi            in   1   SPI data, MSB first, valid on spck rising edge
//  ncs             in   1   SPI chip select, active low; rising edge closes the frame
//  miso            out  1   readback data (see CONFIGURATION)
//  conf_word       out  12  last accepted CONFREG data; major_mode = [8:6]
//  divisor         out  8   last accepted DIVISOR data
//  lf_ed_threshold out  8   last accepted threshold
//  conf_upd        out  1   1-cycle pulse when conf_word is written
//  div_upd         out  1   1-cycle pulse when divisor is written
//  thr_upd         out  1   1-cycle pulse when lf_ed_threshold is written
//  frame_err       out  1   1-cycle pulse on a rejected frame (bit count != FRAME_BITS)
// BEHAVIOUR
//  Reset (nreset=0 on pck0 edge): conf_word=0, divisor=DEFAULT_DIVISOR,
//   lf_ed_threshold=DEFAULT_THRESHOLD, all strobes 0, miso 0, shift reg 0, bit_cnt 0,
//   synchronizers cleared to ncs=1/spck=0, state=WAIT_HIGH.
//  Edges detected on the synchronized signals (last stage vs previous sample). pck0 >= 4x spck.
//  FSM:
//   WAIT_HIGH: after reset; any in-progress frame is ignored; -> IDLE when sync ncs=1.
//   IDLE:  sync ncs falling -> SHIFT, bit_cnt=0.
//   SHIFT: each sync spck rising edge: shift_reg={shift_reg[14:0],mosi_sync}, bit_cnt+1,
//          bit_cnt saturates at 31. sync ncs rising -> DECODE.
//   DECODE (1 cycle): if bit_cnt==FRAME_BITS, act on shift_reg[15:12], else frame_err=1.
//          -> IDLE.
//  Decode: cmd 1: conf_word<=D, conf_upd; if D[8:6]==3'b001 also threshold<=DEFAULT_THRESHOLD,
//   thr_upd. cmd 2: divisor<=D[7:0], div_upd. cmd 3: lf_ed_threshold<=D[7:0], thr_upd.
//   Other cmds (0,4..15): silently ignored, no strobe, no frame_err.
//  Registers and strobes update on the pck0 edge ending DECODE, i.e. SYNC_STAGES+2 pck0 edges
//   after the first edge sampling ncs=1 at the pin.
//  Simultaneous sync spck rise and ncs rise in the same cycle: spck edge ignored.
//  Over-long frame (>16 bits): shift_reg keeps last 16 bits but frame is rejected (frame_err).
//  ncs glitch (fall then rise with 0 bits): bit_cnt=0 -> frame_err pulse, no register change.
//  Reset mid-frame: frame discarded; block waits for ncs high before accepting a new frame.
//  Outputs held between updates; strobes are never asserted in two consecutive cycles.
// CONFIGURATION
//  FPGA_SPI_READBACK_EN defined: on entering SHIFT, a 16-bit tx reg loads {4'b0,conf_word};
//   miso = tx[15]; tx shifts left on each sync spck falling edge while in SHIFT, so the ARM
//   samples current conf_word MSB-first on spck rising edges of the next frame.
//   miso=0 outside SHIFT.
//  Not defined: miso tied 1'b0; no tx register is built.
// TESTING
//  Reset, no SPI -> conf_word=0x000, divisor=95, threshold=127, no strobes, miso=0.
//  Frame 0x1041 (CONFREG, mode 001, field=1) -> conf_word=0x041, threshold=127,
//   conf_upd and thr_upd pulse together once.
//  Frame 0x2017 then 0x307F -> divisor=0x17 with div_upd; threshold=0x7F with thr_upd.
//  15-bit and 17-bit frames of 0x2055 -> frame_err each, divisor unchanged.
//  nreset asserted after 8 bits of 0x2033, released with ncs low -> that frame ignored,
//   following 0x2033 frame accepted.
//  FPGA_SPI_READBACK_EN, conf_word=0x0A5 -> next frame's miso bits = 0x00A5 MSB first.

Source files
------------

// File: rtl/lf_spi_cmd_rx.sv
// lf_spi_cmd_rx: ARM->FPGA SPI command receiver for the LF image.
// Oversamples spck/mosi/ncs in the pck0 domain, assembles 16-bit {C[3:0],D[11:0]}
// frames and decodes CONFREG(1) / DIVISOR(2) / EDGE_DETECT_THRESHOLD(3).
// Optional build macro: FPGA_SPI_READBACK_EN -- when defined, conf_word is shifted
// out on miso during the next frame; otherwise miso is tied low.
module lf_spi_cmd_rx #(
    parameter int FRAME_BITS        = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int DEFAULT_DIVISOR   = 95,
    parameter int DEFAULT_THRESHOLD = 127
) (
    input  logic        pck0,
    input  logic        nreset,
    input  logic        spck,
    input  logic        mosi,
    input  logic        ncs,
    output logic        miso,
    output logic [11:0] conf_word,
    output logic [7:0]  divisor,
    output logic [7:0]  lf_ed_threshold,
    output logic        conf_upd,
    output logic        div_upd,
    output logic        thr_upd,
    output logic        frame_err
);

    typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, DECODE} state_t;

    localparam int          FILL_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);
    localparam logic [4:0]  FRAME_CNT = 5'(FRAME_BITS);
    localparam logic [7:0]  DEF_DIV   = 8'(DEFAULT_DIVISOR);
    localparam logic [7:0]  DEF_THR   = 8'(DEFAULT_THRESHOLD);

    // synchronizers: bit 0 samples the pin, bit SYNC_STAGES-1 is the usable copy
    logic [SYNC_STAGES-1:0] spck_sync_q, mosi_sync_q, ncs_sync_q;
    logic                   spck_prev_q, ncs_prev_q;
    logic [FILL_W-1:0]      fill_q;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] conf_q, conf_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  thr_q, thr_d;
    logic        conf_upd_q, conf_upd_d;
    logic        div_upd_q, div_upd_d;
    logic        thr_upd_q, thr_upd_d;
    logic        ferr_q, ferr_d;

    logic spck_s, mosi_s, ncs_s;
    logic spck_rise, spck_fall, ncs_rise, ncs_fall;

    assign spck_s    = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_prev_q;
    assign spck_fall = ~spck_s & spck_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    // input synchronizers, edge-detect history and post-reset fill counter
    always_ff @(posedge pck0) begin
        if (!nreset) begin
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            fill_q      <= '0;
        end else begin
            spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            spck_prev_q <= spck_s;
            ncs_prev_q  <= ncs_s;
            if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
        end
    end

    // next state, frame assembly and command decode
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        conf_d     = conf_q;
        div_d      = div_q;
        thr_d      = thr_q;
        conf_upd_d = 1'b0;
        div_upd_d  = 1'b0;
        thr_upd_d  = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            // the reset value of the ncs synchronizer is not a real pin sample, so
            // only trust ncs=1 once the chain has been refilled from the pin
            WAIT_HIGH: if (fill_q == FILL_MAX && ncs_s) state_d = IDLE;
            IDLE: if (ncs_fall) begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = DECODE;
                end else if (spck_rise) begin
                    shift_d = {shift_q[14:0], mosi_s};
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (bit_cnt_q != FRAME_CNT) begin
                    ferr_d = 1'b1;
                end else begin
                    case (shift_q[15:12])
                        4'd1: begin
                            conf_d     = shift_q[11:0];
                            conf_upd_d = 1'b1;
                            if (shift_q[8:6] == 3'b001) begin
                                thr_d     = DEF_THR;
                                thr_upd_d = 1'b1;
                            end
                        end
                        4'd2: begin
                            div_d     = shift_q[7:0];
                            div_upd_d = 1'b1;
                        end
                        4'd3: begin
                            thr_d     = shift_q[7:0];
                            thr_upd_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    // state, frame and output registers
    always_ff @(posedge pck0) begin
        if (!nreset) begin
            state_q    <= WAIT_HIGH;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            conf_q     <= '0;
            div_q      <= DEF_DIV;
            thr_q      <= DEF_THR;
            conf_upd_q <= 1'b0;
            div_upd_q  <= 1'b0;
            thr_upd_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            conf_q     <= conf_d;
            div_q      <= div_d;
            thr_q      <= thr_d;
            conf_upd_q <= conf_upd_d;
            div_upd_q  <= div_upd_d;
            thr_upd_q  <= thr_upd_d;
            ferr_q     <= ferr_d;
        end
    end

    assign conf_word       = conf_q;
    assign divisor         = div_q;
    assign lf_ed_threshold = thr_q;
    assign conf_upd        = conf_upd_q;
    assign div_upd         = div_upd_q;
    assign thr_upd         = thr_upd_q;
    assign frame_err       = ferr_q;

`ifdef FPGA_SPI_READBACK_EN
    logic [15:0] tx_q, tx_d;

    // readback: snapshot conf_word at frame start, shift out on spck falling edges
    always_comb begin
        tx_d = tx_q;
        if (state_q == IDLE && ncs_fall) tx_d = {4'b0, conf_q};
        else if (state_q == SHIFT && spck_fall) tx_d = {tx_q[14:0], 1'b0};
    end

    // readback shift register
    always_ff @(posedge pck0) begin
        if (!nreset) tx_q <= '0;
        else         tx_q <= tx_d;
    end

    assign miso = (state_q == SHIFT) ? tx_q[15] : 1'b0;
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// tb_lf_spi_cmd_rx: directed + randomized SPI frames against a frame-level model.
module tb_lf_spi_cmd_rx;

    logic        pck0 = 1'b0;
    logic        nreset = 1'b0;
    logic        spck = 1'b0;
    logic        mosi = 1'b0;
    logic        ncs = 1'b1;
    logic        miso;
    logic [11:0] conf_word;
    logic [7:0]  divisor, lf_ed_threshold;
    logic        conf_upd, div_upd, thr_upd, frame_err;

    int total = 0;
    int bad   = 0;

    // frame-level model state
    logic [11:0] m_conf = 12'h000;
    logic [7:0]  m_div  = 8'd95;
    logic [7:0]  m_thr  = 8'd127;

    logic [3:0] stb;
    logic       prev_any = 1'b0;
    logic       consec   = 1'b0;

    lf_spi_cmd_rx dut (
        .pck0(pck0), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
        .miso(miso), .conf_word(conf_word), .divisor(divisor),
        .lf_ed_threshold(lf_ed_threshold), .conf_upd(conf_upd), .div_upd(div_upd),
        .thr_upd(thr_upd), .frame_err(frame_err)
    );

    always #5 pck0 = ~pck0;

    assign stb = {conf_upd, div_upd, thr_upd, frame_err};

    // flag any strobe asserted in two consecutive cycles
    always @(posedge pck0) begin
        prev_any <= |stb;
        if (prev_any && (|stb)) consec <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // one SPI bit: falling edge + data, then rising edge; miso sampled just before rise
    task automatic spi_bit(input logic b, output logic rb);
        @(negedge pck0);
        spck = 1'b0;
        mosi = b;
        repeat (5) @(negedge pck0);
        rb   = miso;
        spck = 1'b1;
        repeat (5) @(negedge pck0);
    endtask

    task automatic open_frame();
        @(negedge pck0);
        ncs = 1'b0;
        repeat (6) @(negedge pck0);
    endtask

    // close the frame and check strobe timing plus register contents
    task automatic close_frame(input logic [3:0] exp_stb);
        @(negedge pck0);
        spck = 1'b0;
        repeat (5) @(negedge pck0);
        ncs = 1'b1;
        repeat (3) @(posedge pck0);
        #1 chk("stb_early", {28'd0, stb}, 32'd0);
        @(posedge pck0);
        #1 chk("stb", {28'd0, stb}, {28'd0, exp_stb});
        chk("conf", {20'd0, conf_word}, {20'd0, m_conf});
        chk("div", {24'd0, divisor}, {24'd0, m_div});
        chk("thr", {24'd0, lf_ed_threshold}, {24'd0, m_thr});
        @(posedge pck0);
        #1 chk("stb_after", {28'd0, stb}, 32'd0);
        repeat (4) @(negedge pck0);
    endtask

    // full frame of nbits (MSB first from data[nbits-1]) with model update
    task automatic frame(input logic [31:0] data, input int nbits);
        logic [15:0] rbv;
        logic [15:0] rb_exp;
        logic [3:0]  es;
        logic        rb;
        logic [15:0] f;
        rbv = '0;
`ifdef FPGA_SPI_READBACK_EN
        rb_exp = {4'b0, m_conf};
`else
        rb_exp = 16'h0000;
`endif
        open_frame();
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_bit(data[i], rb);
            rbv = {rbv[14:0], rb};
        end
        es = 4'b0000;
        f  = data[15:0];
        if (nbits != 16) begin
            es = 4'b0001;
        end else if (f[15:12] == 4'd1) begin
            m_conf = f[11:0];
            es     = 4'b1000;
            if (f[8:6] == 3'b001) begin
                m_thr = 8'd127;
                es    = 4'b1010;
            end
        end else if (f[15:12] == 4'd2) begin
            m_div = f[7:0];
            es    = 4'b0100;
        end else if (f[15:12] == 4'd3) begin
            m_thr = f[7:0];
            es    = 4'b0010;
        end
        close_frame(es);
        if (nbits == 16) chk("miso_rb", {16'd0, rbv}, {16'd0, rb_exp});
    endtask

    initial begin
        logic rb;
        logic [31:0] d;
        int nb;
        int r;

        repeat (4) @(negedge pck0);
        chk("rst_conf", {20'd0, conf_word}, 32'h000);
        chk("rst_div", {24'd0, divisor}, 32'd95);
        chk("rst_thr", {24'd0, lf_ed_threshold}, 32'd127);
        chk("rst_stb", {28'd0, stb}, 32'd0);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        nreset = 1'b1;
        repeat (8) @(negedge pck0);
        chk("idle_stb", {28'd0, stb}, 32'd0);

        frame(32'h1041, 16);
        frame(32'h2017, 16);
        frame(32'h307F, 16);
        frame(32'h2055, 15);
        frame(32'h12055, 17);
        frame(32'h0, 0);

        // reset in the middle of a 0x2033 frame, released while ncs is still low
        d = 32'h2033;
        open_frame();
        for (int i = 15; i >= 8; i--) spi_bit(d[i], rb);
        @(negedge pck0);
        nreset = 1'b0;
        repeat (3) @(negedge pck0);
        chk("mid_rst_div", {24'd0, divisor}, 32'd95);
        nreset = 1'b1;
        m_conf = 12'h000;
        m_div  = 8'd95;
        m_thr  = 8'd127;
        for (int i = 7; i >= 0; i--) spi_bit(d[i], rb);
        close_frame(4'b0000);
        frame(32'h2033, 16);

        frame(32'h10A5, 16);
        frame(32'h0000, 16);

        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            nb = (r == 0) ? 0 : (r == 1) ? 15 : (r == 2) ? 17 : 16;
            d  = {$urandom} & 32'h1FFFF;
            d[15:12] = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) d[8:6] = 3'b001;
            frame(d, nb);
        end

        chk("no_consec_stb", {31'd0, consec}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
